// File: rtl/pc_sequencer_if.sv
// Interface for pc_sequencer: redirect/control inputs and PC/status outputs.
// The slave modport is the sequencer. The master modport is the core side
// that drives redirects and consumes the fetch PC.
interface pc_sequencer_if;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_top4;
    logic        halted;
    logic        addr_err;
    logic [31:0] epc;

    modport slave (
        input  stall, halt, resume, branch_taken, branch_imm,
               jump, jump_target, jr, jr_target,
        output pc, pc_plus4, pc_top4, halted, addr_err, epc
    );

    modport master (
        output stall, halt, resume, branch_taken, branch_imm,
               jump, jump_target, jr, jr_target,
        input  pc, pc_plus4, pc_top4, halted, addr_err, epc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the single-cycle CPU.
// Handles stall hold, halt/resume and a trap on misaligned jump targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;

    // Sequential adders, both wrap modulo 2^32.
    assign pc_plus4   = pc_q + 32'd4;
    assign branch_tgt = pc_plus4 + {bus.branch_imm[29:0], 2'b00};

    // State, PC and EPC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // Next-state and next-PC selection.
    // The priority chain only looks at a target when its enable is set,
    // so unused target data never reaches the registers.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        case (state_q)
            RUN: begin
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt) begin
                    state_d = HALT;
                end else if (bus.jr) begin
                    if (bus.jr_target[1:0] != 2'b00) begin
                        state_d = TRAP;
                        epc_d   = bus.jr_target;
                    end else begin
                        pc_d = bus.jr_target;
                    end
                end else if (bus.jump) begin
                    if (bus.jump_target[1:0] != 2'b00) begin
                        state_d = TRAP;
                        epc_d   = bus.jump_target;
                    end else begin
                        pc_d = bus.jump_target;
                    end
                end else if (bus.branch_taken) begin
                    pc_d = branch_tgt;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            HALT: begin
                if (bus.resume && !bus.stall) begin
                    state_d = RUN;
                    pc_d    = pc_plus4;
                end
            end
            TRAP: begin
                if (bus.resume && !bus.stall) begin
                    state_d = RUN;
                    pc_d    = TRAP_VECTOR;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs come from registers or pure functions of the PC only.
    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.pc_top4  = pc_plus4[31:28];
    assign bus.halted   = (state_q == HALT);
    assign bus.addr_err = (state_q == TRAP);
    assign bus.epc      = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner
// sequences and random stimulus against a behavioural model.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0080)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        halt;
        logic        resume;
        logic        br;
        logic [31:0] imm;
        logic        jump;
        logic [31:0] jt;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] e_pc;
        logic        e_halted;
        logic        e_err;
        logic [31:0] e_epc;
    } row_t;

    row_t tbl [25];

    // Behavioural model state.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_halted;
    bit          m_trapped;

    function automatic row_t mk(input logic s, input logic h, input logic rs,
                                input logic b, input logic [31:0] imm,
                                input logic j, input logic [31:0] jt,
                                input logic r, input logic [31:0] jrt,
                                input logic [31:0] epc_pc, input logic eh,
                                input logic ee, input logic [31:0] eepc);
        row_t x;
        x.stall = s; x.halt = h; x.resume = rs; x.br = b; x.imm = imm;
        x.jump = j; x.jt = jt; x.jr = r; x.jrt = jrt;
        x.e_pc = epc_pc; x.e_halted = eh; x.e_err = ee; x.e_epc = eepc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input row_t x);
        bus.stall        = x.stall;
        bus.halt         = x.halt;
        bus.resume       = x.resume;
        bus.branch_taken = x.br;
        bus.branch_imm   = x.imm;
        bus.jump         = x.jump;
        bus.jump_target  = x.jt;
        bus.jr           = x.jr;
        bus.jr_target    = x.jrt;
    endtask

    task automatic idle_inputs();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model one clock edge straight from the priority rules.
    task automatic model_step(input row_t x);
        logic [31:0] t;
        if (m_trapped) begin
            if (x.resume && !x.stall) begin
                m_trapped = 0;
                m_pc = 32'h80;
            end
        end else if (m_halted) begin
            if (x.resume && !x.stall) begin
                m_halted = 0;
                m_pc = m_pc + 32'd4;
            end
        end else if (!x.stall) begin
            if (x.halt) begin
                m_halted = 1;
            end else if (x.jr || x.jump) begin
                t = x.jr ? x.jrt : x.jt;
                if (t % 4 != 0) begin
                    m_trapped = 1;
                    m_epc = t;
                end else begin
                    m_pc = t;
                end
            end else if (x.br) begin
                m_pc = m_pc + 32'd4 + x.imm * 32'd4;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(3) != 0) t = t & 32'hFFFF_FFFC;
        return t;
    endfunction

    initial begin
        row_t x;
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset pc", bus.pc, 32'h0);
        check("reset halted", {31'b0, bus.halted}, 32'h0);
        check("reset addr_err", {31'b0, bus.addr_err}, 32'h0);
        check("reset epc", bus.epc, 32'h0);
        check("reset pc_plus4", bus.pc_plus4, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        // Three idle clocks from reset.
        tick(); check("idle pc1", bus.pc, 32'h4);
        tick(); check("idle pc2", bus.pc, 32'h8);
        tick(); check("idle pc3", bus.pc, 32'hC);
        check("idle halted", {31'b0, bus.halted}, 32'h0);

        //            s h r b imm           j jt            r jrt           pc            h e epc
        tbl[0]  = mk(0,0,0,0,0,            0,0,            1,32'h3FFF_FFFC,32'h3FFF_FFFC,0,0,32'h0);
        tbl[1]  = mk(0,0,0,0,0,            1,32'h4123_4560,0,0,            32'h4123_4560,0,0,32'h0);
        tbl[2]  = mk(0,0,0,0,0,            0,0,            1,32'h100,      32'h100,      0,0,32'h0);
        tbl[3]  = mk(0,0,0,1,32'hFFFF_FFFE,0,0,            0,0,            32'hFC,       0,0,32'h0);
        tbl[4]  = mk(0,0,0,0,0,            0,0,            1,32'h100,      32'h100,      0,0,32'h0);
        tbl[5]  = mk(0,0,0,1,32'hFFFF_FFFE,1,32'h200,      0,0,            32'h200,      0,0,32'h0);
        tbl[6]  = mk(0,0,0,0,0,            0,0,            1,32'h2002,     32'h200,      0,1,32'h2002);
        tbl[7]  = mk(0,0,0,0,0,            1,32'h400,      0,0,            32'h200,      0,1,32'h2002);
        tbl[8]  = mk(1,0,1,0,0,            0,0,            0,0,            32'h200,      0,1,32'h2002);
        tbl[9]  = mk(0,0,1,0,0,            0,0,            0,0,            32'h80,       0,0,32'h2002);
        tbl[10] = mk(1,0,0,0,0,            1,32'h300,      0,0,            32'h80,       0,0,32'h2002);
        tbl[11] = mk(1,0,0,0,0,            1,32'h300,      0,0,            32'h80,       0,0,32'h2002);
        tbl[12] = mk(0,0,0,0,0,            1,32'h300,      0,0,            32'h300,      0,0,32'h2002);
        tbl[13] = mk(0,0,0,0,0,            0,0,            1,32'h20,       32'h20,       0,0,32'h2002);
        tbl[14] = mk(0,1,0,0,0,            0,0,            0,0,            32'h20,       1,0,32'h2002);
        tbl[15] = mk(0,0,0,0,0,            0,0,            0,0,            32'h20,       1,0,32'h2002);
        tbl[16] = mk(0,0,0,0,0,            1,32'h500,      0,0,            32'h20,       1,0,32'h2002);
        tbl[17] = mk(0,0,1,0,0,            0,0,            0,0,            32'h24,       0,0,32'h2002);
        tbl[18] = mk(0,0,0,0,0,            1,32'h1001,     0,0,            32'h24,       0,1,32'h1001);
        tbl[19] = mk(0,0,1,0,0,            0,0,            0,0,            32'h80,       0,0,32'h1001);
        tbl[20] = mk(0,0,0,0,0,            0,0,            1,32'hFFFF_FFFC,32'hFFFF_FFFC,0,0,32'h1001);
        tbl[21] = mk(0,0,0,0,0,            0,0,            0,0,            32'h0,        0,0,32'h1001);
        tbl[22] = mk(0,0,0,0,0,            0,0,            1,32'hFFFF_FFFC,32'hFFFF_FFFC,0,0,32'h1001);
        tbl[23] = mk(0,0,0,1,32'h1,        0,0,            0,0,            32'h4,        0,0,32'h1001);
        tbl[24] = mk(1,1,0,0,0,            0,0,            0,0,            32'h4,        0,0,32'h1001);

        foreach (tbl[i]) begin
            if (i == 1) check("top4 before jump", {28'b0, bus.pc_top4}, 32'h4);
            drive(tbl[i]);
            tick();
            check($sformatf("row%0d pc", i), bus.pc, tbl[i].e_pc);
            check($sformatf("row%0d halted", i), {31'b0, bus.halted}, {31'b0, tbl[i].e_halted});
            check($sformatf("row%0d addr_err", i), {31'b0, bus.addr_err}, {31'b0, tbl[i].e_err});
            check($sformatf("row%0d epc", i), bus.epc, tbl[i].e_epc);
            check($sformatf("row%0d pc_plus4", i), bus.pc_plus4, tbl[i].e_pc + 32'd4);
            check($sformatf("row%0d pc_top4", i), {28'b0, bus.pc_top4},
                  {28'b0, 4'((tbl[i].e_pc + 32'd4) >> 28)});
        end

        // Halt for several clocks, then reset asynchronously mid-HALT.
        idle_inputs();
        bus.jr = 1'b1; bus.jr_target = 32'h40;
        tick();
        idle_inputs();
        bus.halt = 1'b1;
        tick();
        idle_inputs();
        for (int n = 0; n < 3; n++) begin
            tick();
            check("halt hold pc", bus.pc, 32'h40);
            check("halt flag", {31'b0, bus.halted}, 32'h1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst pc", bus.pc, 32'h0);
        check("async rst halted", {31'b0, bus.halted}, 32'h0);
        check("async rst epc", bus.epc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post rst pc", bus.pc, 32'h4);

        // Random stimulus against the model.
        m_pc = 32'h4; m_epc = 32'h0; m_halted = 0; m_trapped = 0;
        for (int n = 0; n < 400; n++) begin
            x.stall  = ($urandom_range(7) == 0);
            x.halt   = ($urandom_range(15) == 0);
            x.resume = ($urandom_range(3) == 0);
            x.br     = ($urandom_range(3) == 0);
            x.imm    = ($urandom_range(1) == 0) ? $urandom : 32'($signed($urandom_range(64)) - 32);
            x.jump   = ($urandom_range(7) == 0);
            x.jt     = rnd_tgt();
            x.jr     = ($urandom_range(7) == 0);
            x.jrt    = rnd_tgt();
            drive(x);
            tick();
            model_step(x);
            check("rnd pc", bus.pc, m_pc);
            check("rnd halted", {31'b0, bus.halted}, {31'b0, m_halted});
            check("rnd addr_err", {31'b0, bus.addr_err}, {31'b0, m_trapped});
            check("rnd epc", bus.epc, m_epc);
            check("rnd pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
